// File: rtl/uart_tx_frame_ctrl_pkg.sv
// Shared select codes, FSM states and parity helper
// for the UART transmit path (also used by the TX mux).
package uart_tx_frame_ctrl_pkg;

  localparam logic [2:0] SEL_IDLE  = 3'b000;
  localparam logic [2:0] SEL_START = 3'b001;
  localparam logic [2:0] SEL_DATA  = 3'b011;
  localparam logic [2:0] SEL_PAR   = 3'b010;
  localparam logic [2:0] SEL_STOP  = 3'b110;

  localparam int MAX_WIDTH = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // Zero-extension leaves the XOR-reduce unchanged.
  function automatic logic calc_par(
    input logic [MAX_WIDTH-1:0] d,
    input logic                 odd
  );
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter; presents
// one payload bit per shift, LSB first.
module uart_tx_serializer
  import uart_tx_frame_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  shift_en,
  input  logic                  advance,
  input  logic                  clear,
  output logic                  ser_data,
  output logic                  ser_done
);

  localparam int CW = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] sreg;
  logic [CW-1:0]         cnt;

  // cnt is the index of the bit currently on ser_data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg     <= '0;
      cnt      <= '0;
      ser_data <= 1'b0;
    end else if (load) begin
      sreg     <= data;
      cnt      <= '0;
      ser_data <= 1'b0;
    end else if (clear) begin
      cnt      <= '0;
      ser_data <= 1'b0;
    end else if (shift_en) begin
      ser_data <= sreg[0];
      sreg     <= sreg >> 1;
      if (advance) cnt <= cnt + CW'(1);
    end
  end

  assign ser_done = (cnt == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX frame sequencer: START, DATA, optional
// PARITY, STOP; drives the TX output mux controls.
module uart_tx_frame_ctrl
  import uart_tx_frame_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [2:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  state_t state;
  logic   par_en_q;
  logic   accept;
  logic   ser_done;
  logic   shift_en;
  logic   advance;
  logic   clear;

  assign accept   = (state == ST_IDLE) && Data_Valid;
  assign advance  = (state == ST_DATA) && !ser_done;
  assign clear    = (state == ST_DATA) && ser_done;
  assign shift_en = (state == ST_START) || advance;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk      (CLK),
    .rst_n    (RST),
    .load     (accept),
    .data     (P_DATA),
    .shift_en (shift_en),
    .advance  (advance),
    .clear    (clear),
    .ser_data (ser_data),
    .ser_done (ser_done)
  );

  // Outputs are loaded together with the next state.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= ST_IDLE;
      mux_sel  <= SEL_IDLE;
      par_bit  <= 1'b0;
      busy     <= 1'b0;
      par_en_q <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (Data_Valid) begin
            par_en_q <= PAR_EN;
            par_bit  <= calc_par(
              MAX_WIDTH'(P_DATA), PAR_TYP);
            state    <= ST_START;
            mux_sel  <= SEL_START;
            busy     <= 1'b1;
          end
        end
        ST_START: begin
          state   <= ST_DATA;
          mux_sel <= SEL_DATA;
        end
        ST_DATA: begin
          if (ser_done) begin
            if (par_en_q) begin
              state   <= ST_PARITY;
              mux_sel <= SEL_PAR;
            end else begin
              state   <= ST_STOP;
              mux_sel <= SEL_STOP;
            end
          end
        end
        ST_PARITY: begin
          state   <= ST_STOP;
          mux_sel <= SEL_STOP;
        end
        ST_STOP: begin
          state   <= ST_IDLE;
          mux_sel <= SEL_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          mux_sel <= SEL_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
